// File: rtl/half_adder.sv
// half_adder: WIDTH-lane half adder with a valid-qualified registered tap; HA_CARRY_STATS_EN adds carry statistics.
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Co,
  output logic [WIDTH-1:0] S_q,
  output logic [WIDTH-1:0] Co_q,
  output logic             out_valid
`ifdef HA_CARRY_STATS_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] carry_lanes,
  output logic [CNT_W-1:0]           carry_events
`endif
);
  logic [WIDTH-1:0] s_d, co_d;
  always_comb begin
    S    = A ^ B;
    Co   = A & B;
    s_d  = in_valid ? S : S_q;
    co_d = in_valid ? Co : Co_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_q       <= '0;
      Co_q      <= '0;
      out_valid <= 1'b0;
    end else begin
      S_q       <= s_d;
      Co_q      <= co_d;
      out_valid <= in_valid;
    end
  end
`ifdef HA_CARRY_STATS_EN
  localparam int PW = $clog2(WIDTH+1);
  localparam logic [CNT_W+7:0] MAX = {8'd0, {CNT_W{1'b1}}};
  function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + PW'(v[i]);
    return c;
  endfunction
  logic [CNT_W+7:0] sum;
  logic [CNT_W-1:0] carry_events_d;
  always_comb begin
    carry_lanes    = popcount(Co_q);
    sum            = {8'd0, carry_events} + (CNT_W+8)'(popcount(Co));
    carry_events_d = !in_valid ? carry_events : (sum > MAX) ? MAX[CNT_W-1:0] : sum[CNT_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_events <= '0;
    else        carry_events <= carry_events_d;
  end
`endif
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: directed checks of a 1-lane and a 4-lane half_adder, including async reset and carry stats.
module tb_half_adder;
  logic clk = 1'b0;
  logic rst_n;
  logic iv1, iv4;
  logic [0:0] a1, b1, s1, co1, sq1, coq1;
  logic [3:0] a4, b4, s4, co4, sq4, coq4;
  logic ov1, ov4;
  int total = 0;
  int bad = 0;
`ifdef HA_CARRY_STATS_EN
  logic [2:0] cl4;
  logic [3:0] ce4;
`endif

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .A(a1), .B(b1),
    .S(s1), .Co(co1), .S_q(sq1), .Co_q(coq1), .out_valid(ov1)
`ifdef HA_CARRY_STATS_EN
    , .carry_lanes(), .carry_events()
`endif
  );

  half_adder #(.WIDTH(4), .CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .A(a4), .B(b4),
    .S(s4), .Co(co4), .S_q(sq4), .Co_q(coq4), .out_valid(ov4)
`ifdef HA_CARRY_STATS_EN
    , .carry_lanes(cl4), .carry_events(ce4)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; iv1 = 1'b0; iv4 = 1'b0; a1 = 1'b0; b1 = 1'b0; a4 = '0; b4 = '0;
    #2;
    check("rst_sq1", sq1, 0);
    check("rst_coq1", coq1, 0);
    check("rst_ov1", ov1, 0);
    check("rst_ov4", ov4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1'b0; b1 = 1'b0; #1; check("tt00_s", s1, 0); check("tt00_co", co1, 0);
    a1 = 1'b0; b1 = 1'b1; #1; check("tt01_s", s1, 1); check("tt01_co", co1, 0);
    a1 = 1'b1; b1 = 1'b0; #1; check("tt10_s", s1, 1); check("tt10_co", co1, 0);
    a1 = 1'b1; b1 = 1'b1; #1; check("tt11_s", s1, 0); check("tt11_co", co1, 1);
    iv1 = 1'b1;
    tick();
    check("cap_sq1", sq1, 0);
    check("cap_coq1", coq1, 1);
    check("cap_ov1", ov1, 1);
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
    tick();
    check("hold_ov1", ov1, 0);
    check("hold_sq1", sq1, 0);
    check("hold_coq1", coq1, 1);
    iv4 = 1'b1; a4 = 4'b1100; b4 = 4'b1010;
    #1;
    check("w4_s", s4, 4'b0110);
    check("w4_co", co4, 4'b1000);
    tick();
    check("w4_sq", sq4, 4'b0110);
    check("w4_coq", coq4, 4'b1000);
    check("w4_ov", ov4, 1);
    iv4 = 1'b0; a4 = 4'b0011; b4 = 4'b0001;
    tick();
    check("w4_hold_sq", sq4, 4'b0110);
    check("w4_hold_coq", coq4, 4'b1000);
    check("w4_hold_ov", ov4, 0);
    check("w4_lanes_s", s4, 4'b0010);
    check("w4_lanes_co", co4, 4'b0001);
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    tick();
    check("pre_rst_sq1", sq1, 1);
    check("pre_rst_ov1", ov1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sq1", sq1, 0);
    check("arst_coq1", coq1, 0);
    check("arst_ov1", ov1, 0);
    check("arst_sq4", sq4, 0);
    check("arst_s_comb", s1, 1);
`ifdef HA_CARRY_STATS_EN
    check("arst_events", ce4, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1; a1 = 1'b0; b1 = 1'b1;
    tick();
    check("post_rst_sq1", sq1, 1);
    check("post_rst_coq1", coq1, 0);
    check("post_rst_ov1", ov1, 1);
    iv1 = 1'b0;
    iv4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111;
    tick(); tick(); tick();
    check("b2b_ov4", ov4, 1);
    check("b2b_coq4", coq4, 4'b1111);
`ifdef HA_CARRY_STATS_EN
    check("stat_lanes", cl4, 4);
    check("stat_events12", ce4, 12);
    tick(); tick();
    check("stat_sat15", ce4, 15);
    iv4 = 1'b0;
    tick();
    check("stat_hold15", ce4, 15);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
